// File: rtl/ultrasonic_scan_scheduler.sv
// ultrasonic_scan_scheduler
//
// Round-robin scheduler that fires one ultrasonic sensor driver at a time,
// waits for its completion pulse (or a timeout), then idles for a guard
// interval so residual echoes decay before the next transducer fires. At the
// end of every sweep it publishes the nearest valid obstacle.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   run           level; sweeps repeat while high (sampled in IDLE / sweep end)
//   start_o       one-hot, one-cycle start pulse to the selected driver
//   done_i        one-cycle completion pulse per driver
//   dist_i        driver distances, sensor k at [8k+7:8k]
//   dist_o        latched distance per sensor (8'hFF after a timeout)
//   valid_o       per-sensor: last measurement completed without timeout
//   nearest_dist  minimum valid distance of the last completed sweep
//   nearest_idx   index of nearest_dist (lowest index wins a tie)
//   obstacle      a valid sensor exists and nearest_dist < THRESH
//   sweep_done    one-cycle pulse when a sweep completes
//   busy          high whenever the FSM is not in IDLE
module ultrasonic_scan_scheduler #(
  parameter int          N_SENSORS      = 3,
  parameter int          GUARD_CYCLES   = 16,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  THRESH         = 8'd20,
  localparam int         IW             = $clog2(N_SENSORS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic [N_SENSORS-1:0]   start_o,
  input  logic [N_SENSORS-1:0]   done_i,
  input  logic [8*N_SENSORS-1:0] dist_i,
  output logic [8*N_SENSORS-1:0] dist_o,
  output logic [N_SENSORS-1:0]   valid_o,
  output logic [7:0]             nearest_dist,
  output logic [IW-1:0]          nearest_idx,
  output logic                   obstacle,
  output logic                   sweep_done,
  output logic                   busy
);

  // One timer serves both the WAIT_DONE timeout and the GUARD interval.
  localparam int TMAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]        T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]        G_LAST   = TW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0]        LAST_IDX = IW'(N_SENSORS - 1);
  localparam logic [N_SENSORS-1:0] ONE      = N_SENSORS'(1);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    WAIT_DONE,
    GUARD
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;

  logic [7:0]    sel_dist;
  logic [7:0]    near_d;
  logic [IW-1:0] near_i;
  logic          near_found;

  always_comb begin
    sel_dist = dist_i[8*idx +: 8];
  end

  // Nearest search over the latched results; strict '<' keeps the lowest
  // index on a tie. The final sensor's result is already latched by the time
  // its GUARD ends, so this reflects the complete sweep when sampled.
  always_comb begin
    near_d     = '1;
    near_i     = '0;
    near_found = 1'b0;
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      if (valid_o[i] && (!near_found || dist_o[8*i +: 8] < near_d)) begin
        near_d     = dist_o[8*i +: 8];
        near_i     = IW'(i);
        near_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      timer        <= '0;
      start_o      <= '0;
      dist_o       <= '1;
      valid_o      <= '0;
      nearest_dist <= '1;
      nearest_idx  <= '0;
      obstacle     <= 1'b0;
      sweep_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // start_o is asserted on the edge entering FIRE, so it is high exactly
      // for the FIRE cycle.
      start_o    <= '0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            idx     <= '0;
            start_o <= ONE;
            busy    <= 1'b1;
            state   <= FIRE;
          end
        end

        FIRE: begin
          timer <= '0;
          state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          timer <= timer + TW'(1);
          if (done_i[idx]) begin
            dist_o[8*idx +: 8] <= sel_dist;
            valid_o[idx]       <= 1'b1;
            timer              <= '0;
            state              <= GUARD;
          end else if (timer == T_LAST) begin
            dist_o[8*idx +: 8] <= 8'hFF;
            valid_o[idx]       <= 1'b0;
            timer              <= '0;
            state              <= GUARD;
          end
        end

        GUARD: begin
          if (timer == G_LAST) begin
            timer <= '0;
            if (idx != LAST_IDX) begin
              idx     <= idx + IW'(1);
              start_o <= ONE << (idx + IW'(1));
              state   <= FIRE;
            end else begin
              sweep_done   <= 1'b1;
              nearest_dist <= near_d;
              nearest_idx  <= near_i;
              obstacle     <= near_found && (near_d < THRESH);
              idx          <= '0;
              if (run) begin
                start_o <= ONE;
                state   <= FIRE;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Scoreboard testbench for ultrasonic_scan_scheduler (N=3, GUARD=4, TIMEOUT=20).
module tb_ultrasonic_scan_scheduler;

  localparam int N = 3;
  localparam int G = 4;
  localparam int T = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [2:0]    done_i = '0;
  logic [23:0]   dist_i = '0;
  logic [2:0]    start_o;
  logic [23:0]   dist_o;
  logic [2:0]    valid_o;
  logic [7:0]    nearest_dist;
  logic [1:0]    nearest_idx;
  logic          obstacle;
  logic          sweep_done;
  logic          busy;

  ultrasonic_scan_scheduler #(
    .N_SENSORS(N),
    .GUARD_CYCLES(G),
    .TIMEOUT_CYCLES(T),
    .THRESH(8'd20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .start_o(start_o),
    .done_i(done_i),
    .dist_i(dist_i),
    .dist_o(dist_o),
    .valid_o(valid_o),
    .nearest_dist(nearest_dist),
    .nearest_idx(nearest_idx),
    .obstacle(obstacle),
    .sweep_done(sweep_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct {
    logic [2:0] oh;
    int         c;
  } start_t;

  typedef struct {
    int         c;
    logic [7:0] nd;
    logic [1:0] ni;
    logic       ob;
    logic [2:0] v;
    logic [23:0] d;
  } sweep_t;

  start_t sq[$];
  sweep_t wq[$];

  // ---------------- sensor driver model ----------------
  int         resp_delay [3];
  logic [7:0] resp_dist  [3];
  int         spur_delay = 0;
  int         cnt = 0;
  int         spur_cnt = 0;
  int         sel = 0;

  always @(negedge clk) begin
    done_i = '0;
    if (rst) begin
      cnt      = 0;
      spur_cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done_i[sel]         = 1'b1;
          dist_i[8*sel +: 8]  = resp_dist[sel];
        end
      end
      if (spur_cnt > 0) begin
        spur_cnt--;
        if (spur_cnt == 0) begin
          done_i[2]     = 1'b1;
          dist_i[23:16] = 8'd5;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (start_o[k]) begin
          if (resp_delay[k] > 0) begin
            sel = k;
            cnt = resp_delay[k];
          end
          if (k == 0 && spur_delay > 0) spur_cnt = spur_delay;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  start_t ms;
  sweep_t mw;
  always @(negedge clk) begin
    if (!rst) begin
      if (start_o != '0) begin
        if (sq.size() == 0) begin
          chk("unexpected_start", 32'(start_o), 32'd0);
        end else begin
          ms = sq.pop_front();
          chk("start_onehot", 32'(start_o), 32'(ms.oh));
          chk("start_cycle", cyc, ms.c);
        end
      end
      if (sweep_done) begin
        if (wq.size() == 0) begin
          chk("unexpected_sweep_done", 32'(sweep_done), 32'd0);
        end else begin
          mw = wq.pop_front();
          chk("sweep_cycle", cyc, mw.c);
          chk("nearest_dist", 32'(nearest_dist), 32'(mw.nd));
          chk("nearest_idx", 32'(nearest_idx), 32'(mw.ni));
          chk("obstacle", 32'(obstacle), 32'(mw.ob));
          chk("valid_o", 32'(valid_o), 32'(mw.v));
          chk("dist_o", 32'(dist_o), 32'(mw.d));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_model(input int d0, input int d1, input int d2,
                           input logic [7:0] v0, input logic [7:0] v1,
                           input logic [7:0] v2, input int spur);
    resp_delay[0] = d0; resp_delay[1] = d1; resp_delay[2] = d2;
    resp_dist[0]  = v0; resp_dist[1]  = v1; resp_dist[2]  = v2;
    spur_delay    = spur;
  endtask

  // Push the expected start pulses and sweep result of one sweep whose first
  // FIRE cycle is t0; returns the cycle after the final GUARD.
  task automatic plan(input int t0, input logic [23:0] ed, input logic [2:0] ev,
                      input logic [7:0] en, input logic [1:0] ei, input logic eo,
                      output int tend);
    int t;
    int w;
    start_t s;
    sweep_t r;
    t = t0;
    for (int k = 0; k < N; k++) begin
      s.oh = 3'(1 << k);
      s.c  = t;
      sq.push_back(s);
      w = (resp_delay[k] == 0 || resp_delay[k] > T) ? T : resp_delay[k];
      t = t + 1 + w + G;
    end
    r.c = t; r.nd = en; r.ni = ei; r.ob = eo; r.v = ev; r.d = ed;
    wq.push_back(r);
    tend = t;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sq.size() != 0 || wq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sq.size() + wq.size()), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_start_o"}, 32'(start_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid_o"}, 32'(valid_o), 32'd0);
    chk({tag, "_dist_o"}, 32'(dist_o), 32'hFFFFFF);
    chk({tag, "_nearest_dist"}, 32'(nearest_dist), 32'hFF);
    chk({tag, "_nearest_idx"}, 32'(nearest_idx), 32'd0);
    chk({tag, "_obstacle"}, 32'(obstacle), 32'd0);
    chk({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int x;
    int t;
    set_model(5, 5, 5, 8'd30, 8'd12, 8'd50, 0);
    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // Idle with run low
    repeat (50) begin
      @(negedge clk);
      chk("idle_start_o", 32'(start_o), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_sweep_done", 32'(sweep_done), 32'd0);
    end
    chk("idle_dist_o", 32'(dist_o), 32'hFFFFFF);
    chk("idle_nearest_dist", 32'(nearest_dist), 32'hFF);

    // Full sweep, twice back-to-back (no IDLE between sweeps)
    set_model(5, 5, 5, 8'd30, 8'd12, 8'd50, 0);
    @(negedge clk);
    x = cyc;
    run = 1'b1;
    plan(x + 1, 24'h320C1E, 3'b111, 8'd12, 2'd1, 1'b1, t);
    plan(t, 24'h320C1E, 3'b111, 8'd12, 2'd1, 1'b1, t);
    wait_until(x + 35);
    run = 1'b0;
    drain(200);
    repeat (3) @(negedge clk);
    chk("full_busy_after", 32'(busy), 32'd0);

    // Sensor 1 times out
    set_model(5, 0, 5, 8'd40, 8'd0, 8'd35, 0);
    @(negedge clk);
    x = cyc;
    run = 1'b1;
    plan(x + 1, 24'h23FF28, 3'b101, 8'd35, 2'd2, 1'b0, t);
    wait_until(x + 3);
    run = 1'b0;
    drain(200);

    // Tie, spurious done on non-selected sensor, done coincident with timeout
    set_model(T, 5, 5, 8'd25, 8'd25, 8'd25, 3);
    @(negedge clk);
    x = cyc;
    run = 1'b1;
    plan(x + 1, 24'h191919, 3'b111, 8'd25, 2'd0, 1'b0, t);
    wait_until(x + 3);
    run = 1'b0;
    drain(200);
    spur_delay = 0;

    // run dropped during sensor 1 WAIT_DONE
    set_model(5, 5, 5, 8'd60, 8'd70, 8'd15, 0);
    @(negedge clk);
    x = cyc;
    run = 1'b1;
    plan(x + 1, 24'h0F463C, 3'b111, 8'd15, 2'd2, 1'b1, t);
    wait_until(x + 13);
    run = 1'b0;
    drain(200);
    repeat (30) @(negedge clk);
    chk("rundrop_busy", 32'(busy), 32'd0);

    // Reset during sensor 1 GUARD
    set_model(5, 5, 5, 8'd30, 8'd12, 8'd50, 0);
    @(negedge clk);
    x = cyc;
    run = 1'b1;
    begin
      start_t s;
      s.oh = 3'b001; s.c = x + 1;  sq.push_back(s);
      s.oh = 3'b010; s.c = x + 11; sq.push_back(s);
    end
    wait_until(x + 18);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midreset");
    chk("midreset_starts_seen", 32'(sq.size()), 32'd0);
    rst = 1'b0;
    run = 1'b0;
    set_model(5, 5, 5, 8'd22, 8'd21, 8'd19, 0);
    @(negedge clk);
    x = cyc;
    run = 1'b1;
    plan(x + 1, 24'h131516, 3'b111, 8'd19, 2'd2, 1'b1, t);
    wait_until(x + 3);
    run = 1'b0;
    drain(200);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
